// File: rtl/spram_arbiter_pkg.sv
// Shared types and default widths for the two-requester single-port RAM arbiter.
package spram_arbiter_pkg;

    localparam int ADDR_W_DEFAULT = 10;
    localparam int DATA_W_DEFAULT = 16;

    // One command in flight: accept in IDLE, drive the RAM in ACCESS,
    // collect registered read data in CAPTURE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/spram_arbiter_if.sv
// Requester and RAM-side bus of the arbiter. The arbiter takes the slave
// view; whatever drives the requests and hosts the RAM takes the master view.
interface spram_arbiter_if
    import spram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
);

    logic [1:0]          in_req_valid;
    logic [1:0]          in_req_write;
    logic [2*ADDR_W-1:0] in_req_addr;
    logic [2*DATA_W-1:0] in_req_wdata;
    logic [1:0]          out_req_ready;
    logic [1:0]          out_rsp_valid;
    logic [DATA_W-1:0]   out_rsp_data;
    logic                out_ram_enable;
    logic                out_ram_write;
    logic [ADDR_W-1:0]   out_ram_address;
    logic [DATA_W-1:0]   out_ram_data;
    logic [DATA_W-1:0]   in_ram_data;
    logic                out_busy;

    modport slave (
        input  in_req_valid, in_req_write, in_req_addr, in_req_wdata, in_ram_data,
        output out_req_ready, out_rsp_valid, out_rsp_data,
        output out_ram_enable, out_ram_write, out_ram_address, out_ram_data, out_busy
    );

    modport master (
        output in_req_valid, in_req_write, in_req_addr, in_req_wdata, in_ram_data,
        input  out_req_ready, out_rsp_valid, out_rsp_data,
        input  out_ram_enable, out_ram_write, out_ram_address, out_ram_data, out_busy
    );

endinterface

// File: rtl/spram_rr_pick.sv
// Two-way round-robin picker. The grant is purely combinational from the
// valid lines; the last-grant pointer moves only when a transfer completes,
// so a requester that withdraws before being accepted leaves it untouched.
module spram_rr_pick
    import spram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       take,
    output logic [1:0] grant
);

    // 1 means requester 1 was granted last, so requester 0 wins the next tie.
    logic last;

    // Pick the winner: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember who was served on each completed transfer; reset favours requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (take) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// Two-requester arbiter in front of an external single-port RAM with a
// one-cycle registered read. Commands are accepted only in IDLE, driven to
// the RAM for exactly one cycle, and reads return one cycle later.
module spram_arbiter
    import spram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
)(
    input  logic           in_clock,
    input  logic           in_reset_n,
    spram_arbiter_if.slave bus
);

    state_t            state;
    state_t            state_nx;
    logic [1:0]        grant;
    logic [1:0]        ready;
    logic              fire;
    logic              win;
    logic              winner;
    logic              ram_enable;
    logic              ram_write;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic [1:0]        rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    spram_rr_pick u_pick (
        .clk   (in_clock),
        .rst_n (in_reset_n),
        .valid (bus.in_req_valid),
        .take  (fire),
        .grant (grant)
    );

    // Ready is offered only in IDLE and never while reset is held.
    assign ready = (state == IDLE && in_reset_n) ? grant : 2'b00;
    assign fire  = |(bus.in_req_valid & ready);
    assign win   = grant[1];

    assign bus.out_req_ready   = ready;
    assign bus.out_rsp_valid   = rsp_valid;
    assign bus.out_rsp_data    = rsp_data;
    assign bus.out_ram_enable  = ram_enable;
    assign bus.out_ram_write   = ram_write;
    assign bus.out_ram_address = ram_address;
    assign bus.out_ram_data    = ram_data;
    assign bus.out_busy        = (state != IDLE);

    // State register; reset aborts whatever command is in flight.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: writes finish after ACCESS, reads go through CAPTURE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fire) state_nx = ACCESS;
            ACCESS:  state_nx = ram_write ? IDLE : CAPTURE;
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // RAM command register: loaded on a transfer, enable is a one-cycle pulse,
    // address/data/write hold their last values afterwards.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            ram_enable  <= 1'b0;
            ram_write   <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            winner      <= 1'b0;
        end else begin
            ram_enable <= 1'b0;
            if (fire) begin
                ram_enable  <= 1'b1;
                ram_write   <= bus.in_req_write[win];
                ram_address <= win ? bus.in_req_addr[2*ADDR_W-1:ADDR_W]
                                   : bus.in_req_addr[ADDR_W-1:0];
                ram_data    <= win ? bus.in_req_wdata[2*DATA_W-1:DATA_W]
                                   : bus.in_req_wdata[DATA_W-1:0];
                winner      <= win;
            end
        end
    end

    // Read response: capture RAM output in CAPTURE and strobe the owner once;
    // the data register holds until the next read completes.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            rsp_valid <= 2'b00;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 2'b00;
            if (state == CAPTURE) begin
                rsp_data  <= bus.in_ram_data;
                rsp_valid <= winner ? 2'b10 : 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: directed requests, a behavioural single-port RAM,
// a transfer monitor that logs grants and queues expected read responses,
// and a response monitor that pops and compares them.
module tb_spram_arbiter;
    import spram_arbiter_pkg::*;

    localparam int AW = 10;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    spram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .in_clock   (clk),
        .in_reset_n (rst_n),
        .bus        (bus)
    );

    // Per-requester drive state and the read data each requester expects.
    logic          v [2];
    logic          w [2];
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    logic [DW-1:0] e [2];

    assign bus.in_req_valid = {v[1], v[0]};
    assign bus.in_req_write = {w[1], w[0]};
    assign bus.in_req_addr  = {a[1], a[0]};
    assign bus.in_req_wdata = {d[1], d[0]};

    // Single-port RAM, registered read. Never-written words read as A000|addr.
    logic [DW-1:0] mem     [0:1023];
    logic          written [0:1023];
    logic [DW-1:0] rd;
    logic          ram_clr;
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 1024; i++) written[i] <= 1'b0;
        end else if (bus.out_ram_enable) begin
            if (bus.out_ram_write) begin
                mem[bus.out_ram_address]     <= bus.out_ram_data;
                written[bus.out_ram_address] <= 1'b1;
            end else begin
                rd <= written[bus.out_ram_address] ? mem[bus.out_ram_address]
                                                   : (16'hA000 | 16'(bus.out_ram_address));
            end
        end
    end
    assign bus.in_ram_data = rd;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int rsp_seen = 0;
    int idle_cnt = 0;
    logic cnt_en = 1'b0;

    typedef struct { int id; logic [DW-1:0] data; int at; } rsp_t;
    typedef struct { int id; int at; } gnt_t;
    rsp_t rsp_q [$];
    gnt_t gnt_q [$];
    rsp_t rx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (cnt_en && !bus.out_busy) idle_cnt <= idle_cnt + 1;

    // Transfer monitor: a valid&ready pair seen here completes on the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (v[i] && bus.out_req_ready[i]) begin
                    gnt_q.push_back('{i, cyc + 1});
                    if (!w[i]) rsp_q.push_back('{i, e[i], cyc + 3});
                end
            end
        end
    end

    // Response monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.out_rsp_valid != 2'b00) begin
            rsp_seen++;
            if (rsp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_rsp actual=%0b required=none", bus.out_rsp_valid);
            end else begin
                rx = rsp_q.pop_front();
                chk("rsp_valid", 32'(bus.out_rsp_valid), 32'(1 << rx.id));
                chk("rsp_data", 32'(bus.out_rsp_data), 32'(rx.data));
                chk("rsp_latency", 32'(cyc), 32'(rx.at));
            end
        end
    end

    // Present one command and hold it until accepted; returns 1ns after the transfer edge.
    task automatic req(input int id, input logic wr, input logic [AW-1:0] ad,
                       input logic [DW-1:0] wd, input logic [DW-1:0] ex);
        int n = 0;
        v[id] = 1'b1; w[id] = wr; a[id] = ad; d[id] = wd; e[id] = ex;
        @(negedge clk);
        while (!bus.out_req_ready[id] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_req_ready[id]) begin
            checks++;
            fails++;
            $display("FAIL req_timeout requester=%0d actual=no_ready required=ready", id);
            v[id] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            v[id] = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((rsp_q.size() != 0 || bus.out_busy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (rsp_q.size() != 0 || bus.out_busy) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout actual=pending%0d required=0", rsp_q.size());
            rsp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int t0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; w[i] = 1'b0; a[i] = '0; d[i] = '0; e[i] = '0;
        end
        ram_clr = 1'b1;
        rst_n   = 1'b0;
        v[0]    = 1'b1;
        repeat (3) @(posedge clk);
        ram_clr = 1'b0;
        #1;
        // Outputs held at zero in reset, even with a request pending.
        chk("rst_ready", 32'(bus.out_req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.out_rsp_valid), 32'd0);
        chk("rst_ram_enable", 32'(bus.out_ram_enable), 32'd0);
        chk("rst_busy", 32'(bus.out_busy), 32'd0);
        chk("rst_ram_address", 32'(bus.out_ram_address), 32'd0);
        chk("rst_rsp_data", 32'(bus.out_rsp_data), 32'd0);
        v[0] = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Write 0xBEEF to 0x005 then read it back.
        req(0, 1'b1, 10'h005, 16'hBEEF, 16'h0000);
        chk("wr_ram_enable", 32'(bus.out_ram_enable), 32'd1);
        chk("wr_ram_write", 32'(bus.out_ram_write), 32'd1);
        chk("wr_ram_address", 32'(bus.out_ram_address), 32'h005);
        chk("wr_ram_data", 32'(bus.out_ram_data), 32'hBEEF);
        chk("wr_busy", 32'(bus.out_busy), 32'd1);
        @(posedge clk); #1;
        chk("wr_enable_drop", 32'(bus.out_ram_enable), 32'd0);
        chk("wr_addr_hold", 32'(bus.out_ram_address), 32'h005);
        chk("wr_data_hold", 32'(bus.out_ram_data), 32'hBEEF);
        chk("wr_done_idle", 32'(bus.out_busy), 32'd0);
        req(0, 1'b0, 10'h005, 16'h0000, 16'hBEEF);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rsp_data_hold", 32'(bus.out_rsp_data), 32'hBEEF);

        // Both requesters valid straight out of reset: grants alternate 0,1,0,1.
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        gnt_q.delete();
        fork
            begin
                req(0, 1'b1, 10'h100, 16'h1111, 16'h0000);
                req(0, 1'b1, 10'h101, 16'h2222, 16'h0000);
            end
            begin
                req(1, 1'b1, 10'h200, 16'h3333, 16'h0000);
                req(1, 1'b1, 10'h201, 16'h4444, 16'h0000);
            end
        join
        wait_idle();
        chk("rr_count", 32'(gnt_q.size()), 32'd4);
        if (gnt_q.size() == 4) begin
            chk("rr_g0", 32'(gnt_q[0].id), 32'd0);
            chk("rr_g1", 32'(gnt_q[1].id), 32'd1);
            chk("rr_g2", 32'(gnt_q[2].id), 32'd0);
            chk("rr_g3", 32'(gnt_q[3].id), 32'd1);
            chk("rr_gap", 32'(gnt_q[3].at - gnt_q[0].at), 32'd6);
        end

        // Requester 1 alone, three back-to-back reads of unwritten words.
        idle_cnt = 0;
        req(1, 1'b0, 10'h010, 16'h0000, 16'hA010);
        cnt_en = 1'b1;
        req(1, 1'b0, 10'h011, 16'h0000, 16'hA011);
        req(1, 1'b0, 10'h012, 16'h0000, 16'hA012);
        cnt_en = 1'b0;
        chk("b2b_idle_cycles", 32'(idle_cnt), 32'd2);
        wait_idle();

        // Boundary addresses.
        req(0, 1'b1, 10'h3FF, 16'h1234, 16'h0000);
        req(0, 1'b0, 10'h3FF, 16'h0000, 16'h1234);
        req(0, 1'b0, 10'h000, 16'h0000, 16'hA000);
        wait_idle();
        chk("bound_last_addr", 32'(bus.out_ram_address), 32'h000);

        // Requester 1 arrives while a write is in ACCESS: stalled, then served.
        gnt_q.delete();
        req(0, 1'b1, 10'h020, 16'h5555, 16'h0000);
        t0 = cyc;
        fork
            req(1, 1'b0, 10'h020, 16'h0000, 16'h5555);
            begin
                @(negedge clk);
                chk("stall_ready", 32'(bus.out_req_ready), 32'd0);
                chk("stall_busy", 32'(bus.out_busy), 32'd1);
            end
        join
        wait_idle();
        chk("stall_count", 32'(gnt_q.size()), 32'd2);
        if (gnt_q.size() == 2) begin
            chk("stall_id", 32'(gnt_q[1].id), 32'd1);
            chk("stall_when", 32'(gnt_q[1].at), 32'(t0 + 2));
        end

        // Reset in the CAPTURE cycle of a read aborts it with no response.
        req(0, 1'b0, 10'h005, 16'h0000, 16'hBEEF);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        rsp_q.delete();
        chk("abort_ram_enable", 32'(bus.out_ram_enable), 32'd0);
        chk("abort_rsp_valid", 32'(bus.out_rsp_valid), 32'd0);
        chk("abort_busy", 32'(bus.out_busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        gnt_q.delete();
        fork
            req(0, 1'b1, 10'h030, 16'h6666, 16'h0000);
            req(1, 1'b1, 10'h031, 16'h7777, 16'h0000);
        join
        wait_idle();
        chk("post_rst_count", 32'(gnt_q.size()), 32'd2);
        if (gnt_q.size() == 2) begin
            chk("post_rst_first", 32'(gnt_q[0].id), 32'd0);
            chk("post_rst_second", 32'(gnt_q[1].id), 32'd1);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/spram_arbiter.md
SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, RAM data width.
REQ-003 SHALL have port in_clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port in_reset_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port in_req_valid, input, 2, per-requester command valid (bit i = requester i).
REQ-006 SHALL have port in_req_write, input, 2, per-requester 1=write, 0=read.
REQ-007 SHALL have port in_req_addr, input, 2*ADDR_W, requester i address in bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port in_req_wdata, input, 2*DATA_W, requester i write data in bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port out_req_ready, output, 2, command accept; a transfer occurs on a rising edge where valid[i] and ready[i] are both 1.
REQ-010 SHALL have port out_rsp_valid, output, 2, one-cycle read-response strobe for requester i.
REQ-011 SHALL have port out_rsp_data, output, DATA_W, read data; qualified by out_rsp_valid.
REQ-012 SHALL have port out_ram_enable, output, 1, RAM enable.
REQ-013 SHALL have port out_ram_write, output, 1, RAM write select.
REQ-014 SHALL have port out_ram_address, output, ADDR_W, RAM address.
REQ-015 SHALL have port out_ram_data, output, DATA_W, RAM write data.
REQ-016 SHALL have port in_ram_data, input, DATA_W, RAM registered read data (valid one edge after the RAM samples a read).
REQ-017 SHALL have port out_busy, output, 1, high whenever state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, CAPTURE.
REQ-019 In IDLE, out_req_ready SHALL be combinational: exactly one bit set, for the round-robin winner among valid requesters; all-zero if none valid or state is not IDLE.
REQ-020 Round-robin: a single valid requester wins; if both are valid, the requester not granted last wins; the last-grant pointer updates only on a completed transfer.
REQ-021 On a transfer, the next edge SHALL register the command onto the out_ram_* outputs with out_ram_enable=1, latch the winner ID, and enter ACCESS.
REQ-022 In ACCESS, out_ram_enable SHALL be 1 for exactly this one cycle; the next edge SHALL drive out_ram_enable=0 and enter CAPTURE for a read, or IDLE for a write.
REQ-023 In CAPTURE, the next edge SHALL register in_ram_data into out_rsp_data, pulse out_rsp_valid[winner] for one cycle, and enter IDLE.
REQ-024 Latency: write is 2 cycles from transfer to IDLE; read is 3 cycles from transfer to the edge asserting out_rsp_valid; no pipelining, one command in flight.
REQ-025 out_ram_address, out_ram_data and out_ram_write SHALL hold their last values while out_ram_enable=0.
REQ-026 out_rsp_data SHALL hold its value until the next read response.
REQ-027 A requester deasserting valid before ready SHALL cause no transfer and no pointer change.
REQ-028 Requests arriving while not IDLE SHALL be stalled with ready=0, never dropped.

Reset
REQ-029 While in_reset_n=0, state SHALL be IDLE and all outputs 0; the pointer SHALL be set so that requester 0 wins the first tie.
REQ-030 A reset during ACCESS or CAPTURE SHALL abort the command immediately, clearing out_ram_enable and issuing no response.

Structure
REQ-031 Package spram_arbiter_pkg SHALL hold the FSM state enum and the ADDR_W/DATA_W defaults.
REQ-032 Round-robin winner and pointer logic SHALL be the single sub-module spram_rr_pick.
REQ-033 The RAM SHALL be external; the out_ram_*/in_ram_data ports connect directly to the team's single-port RAM (enable/write/address/data, 1-cycle read).

Verification
REQ-034 Requester 0 writes 0xBEEF to address 0x005, then reads address 0x005 -> out_rsp_valid=2'b01 exactly 3 cycles after the read transfer, with out_rsp_data=0xBEEF.
REQ-035 Both requesters valid continuously from reset -> grants alternate 0,1,0,1 across 4 transfers; no grant is missed.
REQ-036 Requester 1 alone issues 3 back-to-back reads -> it is granted each time; out_busy stays high except 1 IDLE cycle between commands.
REQ-037 Write address 0x3FF, then read 0x3FF and 0x000 -> correct data for both boundary addresses; only the read-of-0x3FF response shows 0x3FF's data.
REQ-038 Assert in_reset_n=0 in the CAPTURE cycle of a read -> no out_rsp_valid, out_ram_enable=0 at once; after release, requester 0 wins the first tie.
REQ-039 Requester 1 raises valid while a write is in ACCESS -> its ready stays 0 until IDLE, then its transfer completes.
